// File: rtl/mac_tcdm_rr_arbiter.sv
// rtl/mac_tcdm_rr_arbiter.sv - round-robin merge of MP TCDM masters onto one memory port
// Define MAC_TCDM_ARB_PERF_EN to add saturating stall/full performance counters.
module mac_tcdm_rr_arbiter #(
    parameter int MP      = 4,
    parameter int MAX_OUT = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [MP-1:0]               tcdm_req,
    output logic [MP-1:0]               tcdm_gnt,
    input  logic [MP-1:0][AW-1:0]       tcdm_add,
    input  logic [MP-1:0]               tcdm_wen,
    input  logic [MP-1:0][DW/8-1:0]     tcdm_be,
    input  logic [MP-1:0][DW-1:0]       tcdm_data,
    output logic [MP-1:0][DW-1:0]       tcdm_r_data,
    output logic [MP-1:0]               tcdm_r_valid,
    output logic                        mem_req,
    input  logic                        mem_gnt,
    output logic [AW-1:0]               mem_add,
    output logic                        mem_wen,
    output logic [DW/8-1:0]             mem_be,
    output logic [DW-1:0]               mem_data,
    input  logic [DW-1:0]               mem_r_data,
    input  logic                        mem_r_valid
`ifdef MAC_TCDM_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_stall_o,
    output logic [31:0]                 perf_full_o
`endif
);

    localparam int PW = $clog2(MP);
    localparam int IW = $clog2(MAX_OUT);
    localparam int CW = IW + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] wptr_q, wptr_d;
    logic [IW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] fifo_q [MAX_OUT];

    logic [PW-1:0] sel;
    logic [PW:0]   cand;
    logic          found;
    logic          full;
    logic          hs;
    logic          pop;
    logic [PW-1:0] head;

    // Rotating priority scan starting at ptr_q, wrapping modulo MP.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < MP; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(MP)) begin
                cand = cand - (PW+1)'(MP);
            end
            if (!found && tcdm_req[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
    end

    // Full is judged on the registered count so a same-cycle pop never frees a slot early.
    assign full    = (cnt_q == CW'(MAX_OUT));
    assign mem_req = !rst_i && (|tcdm_req) && !full;
    assign hs      = mem_req && mem_gnt;
    assign pop     = !rst_i && mem_r_valid && (cnt_q != '0);
    assign head    = fifo_q[rptr_q];

    assign mem_add  = mem_req ? tcdm_add[sel]  : '0;
    assign mem_wen  = mem_req ? tcdm_wen[sel]  : 1'b0;
    assign mem_be   = mem_req ? tcdm_be[sel]   : '0;
    assign mem_data = mem_req ? tcdm_data[sel] : '0;

    always_comb begin
        tcdm_gnt     = '0;
        tcdm_r_valid = '0;
        tcdm_r_data  = '0;
        if (hs) begin
            tcdm_gnt[sel] = 1'b1;
        end
        if (pop) begin
            tcdm_r_valid[head] = 1'b1;
            tcdm_r_data[head]  = mem_r_data;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (hs) begin
            ptr_d  = (sel == PW'(MP-1)) ? '0 : sel + PW'(1);
            wptr_d = wptr_q + IW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + IW'(1);
        end
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // FIFO payload needs no reset: the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wptr_q] <= sel;
        end
    end

`ifdef MAC_TCDM_ARB_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] fullc_q, fullc_d;

    always_comb begin
        stall_d = stall_q;
        fullc_d = fullc_q;
        if ((|tcdm_req) && !hs && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (full && (|tcdm_req) && (fullc_q != '1)) begin
            fullc_d = fullc_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            fullc_q <= '0;
        end else begin
            stall_q <= stall_d;
            fullc_q <= fullc_d;
        end
    end

    assign perf_stall_o = stall_q;
    assign perf_full_o  = fullc_q;
`endif

endmodule
